// File: rtl/frq_ctrl_pkg.sv
// Shared types and constants for the divider sweep controller.
package frq_ctrl_pkg;

    localparam int FRQ_SEL_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } frq_state_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_PP   = 2'b11;

endpackage

// File: rtl/frq_edge_det.sv
// Single-register edge detector for a signal already synchronous to clk.
module frq_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // Remember the previous level so the current one can be compared with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/frq_sweep_ctrl.sv
// Sweeps the divider frequency select over a range, changing it only just
// after a divider output fall so the output never sees a runt pulse.
module frq_sweep_ctrl
    import frq_ctrl_pkg::*;
#(
    parameter int SEL_W   = FRQ_SEL_W,
    parameter int DWELL_W = 8,
    parameter int WD_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   f_lo,
    input  logic [SEL_W-1:0]   f_hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               clk_div_in,
    output logic [SEL_W-1:0]   f_select,
    output logic               busy,
    output logic               step_pulse,
    output logic               done,
    output logic               err
);

    localparam logic [SEL_W-1:0]   SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]    WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
    // Counter value whose increment reaches all-ones, i.e. the trip point
    localparam logic [WD_W-1:0]    WD_TRIP = {{(WD_W-1){1'b1}}, 1'b0};

    frq_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;
    logic [SEL_W-1:0]   lo_q, lo_d;
    logic [SEL_W-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               rise;
    logic               fall;
    logic [SEL_W-1:0]   lo_in;
    logic [SEL_W-1:0]   hi_in;

    frq_edge_det u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (clk_div_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A reversed range is accepted and simply put back in order
    assign lo_in = (f_lo > f_hi) ? f_hi : f_lo;
    assign hi_in = (f_lo > f_hi) ? f_lo : f_hi;

    // Next-state logic: sequencing, dwell counting, watchdog and stepping
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dwell_d = dwell_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d  = mode;
                    lo_d    = lo_in;
                    hi_d    = hi_in;
                    dwell_d = (dwell == '0) ? DW_ONE : dwell;
                    err_d   = 1'b0;
                    sel_d   = (mode == MODE_DOWN) ? hi_in : lo_in;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    wd_d    = '0;
                    dir_d   = 1'b1;
                    state_d = ARM;
                end
            end

            ARM, DWELL: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!rise && !fall) begin
                    wd_d = wd_q + WD_ONE;
                    if (wd_q == WD_TRIP) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    wd_d = '0;
                    if (state_q == ARM) begin
                        if (fall) begin
                            cnt_d   = '0;
                            state_d = DWELL;
                        end
                    end else begin
                        if (rise && (cnt_q != dwell_q)) begin
                            cnt_d = cnt_q + DW_ONE;
                        end
                        if (fall && (cnt_q == dwell_q)) begin
                            cnt_d = '0;
                            case (mode_q)
                                MODE_HOLD: begin
                                end
                                MODE_UP: begin
                                    if (sel_q == hi_q) begin
                                        state_d = DONE;
                                    end else begin
                                        sel_d  = sel_q + SEL_ONE;
                                        step_d = 1'b1;
                                    end
                                end
                                MODE_DOWN: begin
                                    if (sel_q == lo_q) begin
                                        state_d = DONE;
                                    end else begin
                                        sel_d  = sel_q - SEL_ONE;
                                        step_d = 1'b1;
                                    end
                                end
                                MODE_PP: begin
                                    step_d = 1'b1;
                                    if (lo_q != hi_q) begin
                                        if (sel_q == hi_q) begin
                                            dir_d = 1'b0;
                                        end else if (sel_q == lo_q) begin
                                            dir_d = 1'b1;
                                        end
                                        sel_d = dir_d ? (sel_q + SEL_ONE) : (sel_q - SEL_ONE);
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                done_d  = !stop;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
            dir_q   <= 1'b1;
            mode_q  <= MODE_HOLD;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dwell_q <= dwell_d;
        end
    end

    assign f_select   = sel_q;
    assign busy       = busy_q;
    assign step_pulse = step_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/frq_sweep_ctrl.md
Name: frq_sweep_ctrl

Overview:
- Sequencer that drives the 5-bit F_select input of the ROM-controlled frequency divider.
- Steps the selection through a programmed range, holding each setting for a programmable number of divider output periods.
- Changes F_select only just after a falling edge of the divider output, so the output never gets a runt pulse.
- Sits beside the divider inside the top-level wrapper and takes its control from the dedicated inputs.

Parameters:
- SEL_W, 5: width of the frequency select; matches the divider ROM address.
- DWELL_W, 8: width of the dwell count, in divider output periods.
- WD_W, 16: width of the watchdog counter, in clk cycles without a divider edge.

Ports:
- clk  in  1  system clock; also clocks the divider.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence; sampled in IDLE only.
- stop  in  1  abort request; honoured in any state.
- mode  in  2  00 hold, 01 sweep up once, 10 sweep down once, 11 ping-pong continuous.
- f_lo  in  SEL_W  low end of the range.
- f_hi  in  SEL_W  high end of the range.
- dwell  in  DWELL_W  rising edges of clk_div_in per setting; 0 is treated as 1.
- clk_div_in  in  1  divider output fed back, synchronous to clk.
- f_select  out  SEL_W  drives the divider F_select.
- busy  out  1  high while a sequence is active.
- step_pulse  out  1  one-cycle pulse on each f_select change.
- done  out  1  one-cycle pulse when a once-mode sweep completes.
- err  out  1  sticky watchdog flag; cleared by an accepted start.

Behaviour:
- Reset values: state IDLE; f_select 0; busy, step_pulse, done, err 0; all counters 0; direction up.
- Edge detect: one register stage on clk_div_in.
  - rise = in & ~q.
  - fall = ~in & q.
- IDLE:
  - When start=1 and stop=0: latch mode, f_lo, f_hi and dwell (0 becomes 1); clear err.
  - f_select loads the start value on that same edge: f_hi for mode 10, otherwise f_lo. It is visible the next cycle.
  - busy=1 from the next cycle; go to ARM.
  - If f_lo > f_hi, swap the two when latching.
- ARM: wait for the first fall, then enter DWELL with rise count 0. This aligns counting to a full period.
- DWELL: increment the rise count on each rise. Once count == dwell, the next fall triggers the step decision on that cycle:
  - mode 00: clear count and stay in DWELL. f_select is unchanged and there is no step_pulse.
  - mode 01: if f_select == f_hi, go to DONE; else f_select+1.
  - mode 10: if f_select == f_lo, go to DONE; else f_select-1.
  - mode 11: step in the current direction. At f_hi the direction reverses to down; at f_lo it reverses to up. The step is taken after reversal.
  - mode 11 with f_lo == f_hi: f_select stays put, but step_pulse still fires.
  - On any step: step_pulse=1 for one cycle, count cleared, remain in DWELL. The new f_select is registered and appears the cycle after the fall.
- DONE: done=1 for one cycle, busy=0, return to IDLE. f_select holds its last value.
- stop:
  - Any non-IDLE state goes to IDLE on the next edge; busy drops and f_select holds.
  - No done pulse.
  - stop and start in the same cycle: stop wins and start is ignored.
- start while busy: ignored.
- Watchdog:
  - In ARM or DWELL, the counter increments every clk without a rise or fall, and clears on any edge.
  - At all-ones: set err, go to IDLE, busy=0, no done pulse.
- f_select never wraps: steps are bounded by f_lo and f_hi.
- All outputs are registered.

Decomposition:
- Package frq_ctrl_pkg holds:
  - the state enum (IDLE, ARM, DWELL, DONE);
  - mode constants MODE_HOLD, MODE_UP, MODE_DOWN, MODE_PP;
  - SEL_W default.
- One sub-module, frq_edge_det: the register plus rise/fall outputs with async reset. It is reusable for other divider-feedback monitors.
- The rest (FSM, dwell counter, watchdog, f_select register) stays in frq_sweep_ctrl.

Test Plan:
- Up sweep with one-cycle rise per period: reset, then start with mode=01, f_lo=2, f_hi=4, dwell=3, and clk_div_in a period-4 square wave.
  - f_select goes 2→3→4.
  - Each change comes one cycle after the 3rd-period fall.
  - Two step_pulses, then done pulses once and busy=0 with f_select=4.
- Ping-pong: mode=11, f_lo=1, f_hi=3, dwell=1.
  - Sequence 1,2,3,2,1,2…
  - One step_pulse per period, busy stays 1.
- Stop mid-sweep: stop in DWELL at f_select=3.
  - Next cycle IDLE, busy=0, f_select=3, no done.
  - Also check start+stop in the same cycle leaves the block IDLE.
- Swapped bounds and zero dwell: mode=10, f_lo=7, f_hi=5, dwell=0.
  - Start value 7, then 6, then 5, one period each, then done.
- Watchdog: hold clk_div_in low after ARM with WD_W=4.
  - err=1 and busy=0 after 15 idle cycles.
  - The next start clears err.
- Async reset mid-DWELL: assert reset_n=0 between clock edges.
  - All outputs return to 0 immediately, with no clock needed.
